// File: rtl/pc_unit.sv
// pc_unit: program counter sequencer with optional hardware return stack.
//
// Computes the next instruction fetch address each clock. Inside the RUN
// state the sources are ranked, highest first:
//   halt_req, stall, ret, call, jump, branch_take, increment.
// A small state machine (IDLE, RUN, STALL, HALT) decides when a fetch is
// valid. Every output comes straight from a register.
//
// Build option:
//   PC_RETURN_STACK_EN - when defined, adds an RS_DEPTH-entry LIFO return
//                        stack. call pushes pc+1 onto it and ret pops from it.
//                        When not defined, call behaves like jump, ret
//                        behaves like a plain increment, and rs_depth and
//                        rs_err are held at zero.
//
// Parameters:
//   RESET_VECTOR - value loaded into pc while reset is asserted
//   RS_DEPTH     - number of return-stack entries (2 or 4, so that the
//                  occupancy fits in the 3-bit rs_depth output)
//
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   stall        in   hold pc this cycle
//   jump         in   load jump_addr
//   jump_addr    in   16-bit absolute target, used by jump and call
//   branch_take  in   take the PC-relative branch
//   branch_off   in   8-bit signed word offset
//   call         in   subroutine call to jump_addr
//   ret          in   return to the address on top of the return stack
//   halt_req     in   enter HALT
//   resume       in   leave HALT
//   pc           out  current fetch address
//   fetch_valid  out  high exactly while the block is in RUN
//   halted       out  high while the block is in HALT
//   instr_count  out  saturating count of pc changes made in RUN
//   rs_depth     out  current return-stack occupancy
//   rs_err       out  sticky return-stack overflow/underflow flag
module pc_unit #(
  parameter logic [15:0] RESET_VECTOR = 16'h0000,
  parameter int          RS_DEPTH     = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        jump,
  input  logic [15:0] jump_addr,
  input  logic        branch_take,
  input  logic [7:0]  branch_off,
  input  logic        call,
  input  logic        ret,
  input  logic        halt_req,
  input  logic        resume,
  output logic [15:0] pc,
  output logic        fetch_valid,
  output logic        halted,
  output logic [15:0] instr_count,
  output logic [2:0]  rs_depth,
  output logic        rs_err
);

  // rs_depth is only 3 bits wide, and the stack pointer wraps by plain
  // binary overflow, so the depth must be a power of two no larger than 4.
  if ((RS_DEPTH < 2) || (RS_DEPTH > 4) || ((RS_DEPTH & (RS_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("pc_unit: RS_DEPTH must be 2 or 4");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] pc_nxt;
  logic [15:0] pc_inc;
  logic [15:0] br_target;
  logic [15:0] count_nxt;

`ifdef PC_RETURN_STACK_EN
  localparam int PW = $clog2(RS_DEPTH);
  localparam int CW = $clog2(RS_DEPTH + 1);
  localparam logic [CW-1:0] RS_FULL = CW'(RS_DEPTH);

  logic [15:0]   rs_mem [RS_DEPTH];
  logic [PW-1:0] rs_top_idx;
  logic [PW-1:0] rs_push_idx;
  logic [CW-1:0] rs_cnt;
  logic [15:0]   rs_top;
  logic          rs_push;
  logic          rs_pop;
  logic          rs_err_set;

  // The stack is a circular buffer. When it is full, a push lands on the
  // oldest entry, so the newest RS_DEPTH return addresses are always kept.
  assign rs_push_idx = rs_top_idx + PW'(1);
  assign rs_top      = rs_mem[rs_top_idx];
`endif

  assign pc_inc    = pc + 16'd1;
  assign br_target = pc_inc + {{8{branch_off[7]}}, branch_off};

  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
`ifdef PC_RETURN_STACK_EN
    rs_push    = 1'b0;
    rs_pop     = 1'b0;
    rs_err_set = 1'b0;
`endif
    unique case (state)
      IDLE: state_nxt = RUN;
      RUN: begin
        if (halt_req) begin
          state_nxt = HALT;
        end else if (stall) begin
          state_nxt = STALL;
        end else if (ret) begin
`ifdef PC_RETURN_STACK_EN
          // A return with an empty stack still moves forward, but it is
          // recorded as an error.
          if (rs_cnt == '0) begin
            pc_nxt     = pc_inc;
            rs_err_set = 1'b1;
          end else begin
            pc_nxt = rs_top;
            rs_pop = 1'b1;
          end
`else
          pc_nxt = pc_inc;
`endif
        end else if (call) begin
          pc_nxt = jump_addr;
`ifdef PC_RETURN_STACK_EN
          rs_push = 1'b1;
`endif
        end else if (jump) begin
          pc_nxt = jump_addr;
        end else if (branch_take) begin
          pc_nxt = br_target;
        end else begin
          pc_nxt = pc_inc;
        end
      end
      // Leaving STALL re-enters RUN with pc unchanged. The held address
      // is then fetched again, this time with fetch_valid asserted.
      STALL: begin
        if (halt_req) begin
          state_nxt = HALT;
        end else if (!stall) begin
          state_nxt = RUN;
        end
      end
      HALT: begin
        if (resume && !halt_req) begin
          state_nxt = RUN;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Only real changes of pc are counted, so a jump to the current address
  // does not advance the count. The count stops at all-ones.
  always_comb begin
    count_nxt = instr_count;
    if ((state == RUN) && (pc_nxt != pc) && (instr_count != 16'hFFFF)) begin
      count_nxt = instr_count + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= RESET_VECTOR;
      fetch_valid <= 1'b0;
      halted      <= 1'b0;
      instr_count <= 16'h0000;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      fetch_valid <= (state_nxt == RUN);
      halted      <= (state_nxt == HALT);
      instr_count <= count_nxt;
    end
  end

`ifdef PC_RETURN_STACK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        rs_mem[i] <= 16'h0000;
      end
      rs_top_idx <= '0;
      rs_cnt     <= '0;
      rs_err     <= 1'b0;
    end else begin
      if (rs_push) begin
        rs_mem[rs_push_idx] <= pc_inc;
        rs_top_idx          <= rs_push_idx;
        if (rs_cnt == RS_FULL) begin
          rs_err <= 1'b1;
        end else begin
          rs_cnt <= rs_cnt + CW'(1);
        end
      end else if (rs_pop) begin
        rs_top_idx <= rs_top_idx - PW'(1);
        rs_cnt     <= rs_cnt - CW'(1);
      end
      if (rs_err_set) begin
        rs_err <= 1'b1;
      end
    end
  end

  assign rs_depth = 3'(rs_cnt);
`else
  assign rs_depth = 3'd0;
  assign rs_err   = 1'b0;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: scoreboard testbench for pc_unit.
// Each stimulus step drives the inputs on a falling edge and queues the
// register values expected after the next rising edge. A separate monitor
// takes one entry from the queue shortly after each rising edge and
// compares it with the DUT outputs. Checks made during reset are done
// directly, because reset does not depend on the clock.
module tb_pc_unit;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        jump;
  logic [15:0] jump_addr;
  logic        branch_take;
  logic [7:0]  branch_off;
  logic        call;
  logic        ret;
  logic        halt_req;
  logic        resume;
  logic [15:0] pc;
  logic        fetch_valid;
  logic        halted;
  logic [15:0] instr_count;
  logic [2:0]  rs_depth;
  logic        rs_err;

  int total = 0;
  int bad   = 0;

  // Control vector bit order: {stall, jump, branch_take, call, ret, halt_req, resume}
  localparam logic [6:0] NONE = 7'h00;
  localparam logic [6:0] S    = 7'h40;
  localparam logic [6:0] J    = 7'h20;
  localparam logic [6:0] B    = 7'h10;
  localparam logic [6:0] C    = 7'h08;
  localparam logic [6:0] R    = 7'h04;
  localparam logic [6:0] H    = 7'h02;
  localparam logic [6:0] RES  = 7'h01;

`ifdef PC_RETURN_STACK_EN
  localparam logic [15:0] CNT_BASE  = 16'd22;
  localparam logic        ERR_AFTER = 1'b1;
`else
  localparam logic [15:0] CNT_BASE  = 16'd14;
  localparam logic        ERR_AFTER = 1'b0;
`endif

  typedef struct {
    string       tag;
    logic [15:0] pc;
    logic        fv;
    logic        hl;
    logic [15:0] cnt;
    logic [2:0]  dep;
    logic        err;
  } exp_t;

  exp_t expQ[$];

  pc_unit #(
    .RESET_VECTOR(16'h0000),
    .RS_DEPTH(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .stall(stall),
    .jump(jump),
    .jump_addr(jump_addr),
    .branch_take(branch_take),
    .branch_off(branch_off),
    .call(call),
    .ret(ret),
    .halt_req(halt_req),
    .resume(resume),
    .pc(pc),
    .fetch_valid(fetch_valid),
    .halted(halted),
    .instr_count(instr_count),
    .rs_depth(rs_depth),
    .rs_err(rs_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic checkAll(input string tag, input logic [15:0] ePc, input logic eFv,
                          input logic eHl, input logic [15:0] eCnt, input logic [2:0] eDep,
                          input logic eErr);
    checkOutput({tag, ".pc"}, pc, ePc);
    checkOutput({tag, ".fetch_valid"}, 16'(fetch_valid), 16'(eFv));
    checkOutput({tag, ".halted"}, 16'(halted), 16'(eHl));
    checkOutput({tag, ".instr_count"}, instr_count, eCnt);
    checkOutput({tag, ".rs_depth"}, 16'(rs_depth), 16'(eDep));
    checkOutput({tag, ".rs_err"}, 16'(rs_err), 16'(eErr));
  endtask

  task automatic pushExpect(input string tag, input logic [15:0] ePc, input logic eFv,
                            input logic eHl, input logic [15:0] eCnt, input logic [2:0] eDep,
                            input logic eErr);
    exp_t e;
    e.tag = tag;
    e.pc  = ePc;
    e.fv  = eFv;
    e.hl  = eHl;
    e.cnt = eCnt;
    e.dep = eDep;
    e.err = eErr;
    expQ.push_back(e);
  endtask

  task automatic applyStimulus(input string tag, input logic [6:0] ctl, input logic [15:0] ja,
                               input logic [7:0] bo, input logic [15:0] ePc, input logic eFv,
                               input logic eHl, input logic [15:0] eCnt, input logic [2:0] eDep,
                               input logic eErr);
    @(negedge clk);
    {stall, jump, branch_take, call, ret, halt_req, resume} = ctl;
    jump_addr  = ja;
    branch_off = bo;
    pushExpect(tag, ePc, eFv, eHl, eCnt, eDep, eErr);
  endtask

  // Monitor: one queued expectation per rising edge, sampled 1 ns later.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        exp_t e;
        e = expQ.pop_front();
        checkAll(e.tag, e.pc, e.fv, e.hl, e.cnt, e.dep, e.err);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n       = 1'b0;
    {stall, jump, branch_take, call, ret, halt_req, resume} = NONE;
    jump_addr   = 16'h0000;
    branch_off  = 8'h00;

    #12;
    checkAll("reset", 16'h0000, 1'b0, 1'b0, 16'd0, 3'd0, 1'b0);

    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkAll("idle", 16'h0000, 1'b0, 1'b0, 16'd0, 3'd0, 1'b0);
    pushExpect("idle_to_run", 16'h0000, 1'b1, 1'b0, 16'd0, 3'd0, 1'b0);

    // Free-running increment
    applyStimulus("inc1", NONE, 16'h0000, 8'h00, 16'h0001, 1'b1, 1'b0, 16'd1, 3'd0, 1'b0);
    applyStimulus("inc2", NONE, 16'h0000, 8'h00, 16'h0002, 1'b1, 1'b0, 16'd2, 3'd0, 1'b0);
    applyStimulus("inc3", NONE, 16'h0000, 8'h00, 16'h0003, 1'b1, 1'b0, 16'd3, 3'd0, 1'b0);

    // Backward branch: 0x10 + 1 - 4 = 0x0D
    applyStimulus("jmp10", J, 16'h0010, 8'h00, 16'h0010, 1'b1, 1'b0, 16'd4, 3'd0, 1'b0);
    applyStimulus("brback", B, 16'h0000, 8'hFC, 16'h000D, 1'b1, 1'b0, 16'd5, 3'd0, 1'b0);

    // Wraparound from FFFF
    applyStimulus("jmpffff", J, 16'hFFFF, 8'h00, 16'hFFFF, 1'b1, 1'b0, 16'd6, 3'd0, 1'b0);
    applyStimulus("wrap", NONE, 16'h0000, 8'h00, 16'h0000, 1'b1, 1'b0, 16'd7, 3'd0, 1'b0);

    // jump outranks branch_take
    applyStimulus("jmpbr", J | B, 16'h0200, 8'h05, 16'h0200, 1'b1, 1'b0, 16'd8, 3'd0, 1'b0);

    // Three stall cycles, then re-enter RUN at the held pc, then +1
    applyStimulus("stall1", S, 16'h0000, 8'h00, 16'h0200, 1'b0, 1'b0, 16'd8, 3'd0, 1'b0);
    applyStimulus("stall2", S, 16'h0000, 8'h00, 16'h0200, 1'b0, 1'b0, 16'd8, 3'd0, 1'b0);
    applyStimulus("stall3", S, 16'h0000, 8'h00, 16'h0200, 1'b0, 1'b0, 16'd8, 3'd0, 1'b0);
    applyStimulus("unstall", NONE, 16'h0000, 8'h00, 16'h0200, 1'b1, 1'b0, 16'd8, 3'd0, 1'b0);
    applyStimulus("postst", NONE, 16'h0000, 8'h00, 16'h0201, 1'b1, 1'b0, 16'd9, 3'd0, 1'b0);

    // Halt at 0x0005, halt_req with resume keeps HALT, resume alone leaves
    applyStimulus("jmp5", J, 16'h0005, 8'h00, 16'h0005, 1'b1, 1'b0, 16'd10, 3'd0, 1'b0);
    applyStimulus("halt", H, 16'h0000, 8'h00, 16'h0005, 1'b0, 1'b1, 16'd10, 3'd0, 1'b0);
    applyStimulus("haltres", H | RES, 16'h0000, 8'h00, 16'h0005, 1'b0, 1'b1, 16'd10, 3'd0, 1'b0);
    applyStimulus("resume", RES, 16'h0000, 8'h00, 16'h0005, 1'b1, 1'b0, 16'd10, 3'd0, 1'b0);
    applyStimulus("posthalt", NONE, 16'h0000, 8'h00, 16'h0006, 1'b1, 1'b0, 16'd11, 3'd0, 1'b0);

    // Jump to the current address: pc unchanged, so no count
    applyStimulus("jmpsame", J, 16'h0006, 8'h00, 16'h0006, 1'b1, 1'b0, 16'd11, 3'd0, 1'b0);

    // halt_req beats stall while in STALL
    applyStimulus("st2halt_a", S, 16'h0000, 8'h00, 16'h0006, 1'b0, 1'b0, 16'd11, 3'd0, 1'b0);
    applyStimulus("st2halt_b", S | H, 16'h0000, 8'h00, 16'h0006, 1'b0, 1'b1, 16'd11, 3'd0, 1'b0);
    applyStimulus("st2halt_c", RES, 16'h0000, 8'h00, 16'h0006, 1'b1, 1'b0, 16'd11, 3'd0, 1'b0);

`ifdef PC_RETURN_STACK_EN
    // Five calls starting at pc 0x0001: the fifth overwrites return address 0x0002
    applyStimulus("jmp1", J, 16'h0001, 8'h00, 16'h0001, 1'b1, 1'b0, 16'd12, 3'd0, 1'b0);
    applyStimulus("call1", C, 16'h0100, 8'h00, 16'h0100, 1'b1, 1'b0, 16'd13, 3'd1, 1'b0);
    applyStimulus("call2", C, 16'h0200, 8'h00, 16'h0200, 1'b1, 1'b0, 16'd14, 3'd2, 1'b0);
    applyStimulus("call3", C, 16'h0300, 8'h00, 16'h0300, 1'b1, 1'b0, 16'd15, 3'd3, 1'b0);
    applyStimulus("call4", C, 16'h0400, 8'h00, 16'h0400, 1'b1, 1'b0, 16'd16, 3'd4, 1'b0);
    applyStimulus("call5", C, 16'h0500, 8'h00, 16'h0500, 1'b1, 1'b0, 16'd17, 3'd4, 1'b1);
    applyStimulus("ret1", R, 16'h0000, 8'h00, 16'h0401, 1'b1, 1'b0, 16'd18, 3'd3, 1'b1);
    applyStimulus("ret2", R, 16'h0000, 8'h00, 16'h0301, 1'b1, 1'b0, 16'd19, 3'd2, 1'b1);
    applyStimulus("ret3", R, 16'h0000, 8'h00, 16'h0201, 1'b1, 1'b0, 16'd20, 3'd1, 1'b1);
    applyStimulus("ret4", R, 16'h0000, 8'h00, 16'h0101, 1'b1, 1'b0, 16'd21, 3'd0, 1'b1);
    applyStimulus("ret5", R, 16'h0000, 8'h00, 16'h0102, 1'b1, 1'b0, 16'd22, 3'd0, 1'b1);
`else
    // Without the stack: call acts as jump, ret as increment and outranks call
    applyStimulus("call", C, 16'h0100, 8'h00, 16'h0100, 1'b1, 1'b0, 16'd12, 3'd0, 1'b0);
    applyStimulus("ret", R, 16'h0000, 8'h00, 16'h0101, 1'b1, 1'b0, 16'd13, 3'd0, 1'b0);
    applyStimulus("retcall", R | C, 16'h0300, 8'h00, 16'h0102, 1'b1, 1'b0, 16'd14, 3'd0, 1'b0);
`endif

    // Reset pulse in the middle of a STALL at 0x0040
    applyStimulus("jmp40", J, 16'h0040, 8'h00, 16'h0040, 1'b1, 1'b0, CNT_BASE + 16'd1, 3'd0, ERR_AFTER);
    applyStimulus("stall40", S, 16'h0000, 8'h00, 16'h0040, 1'b0, 1'b0, CNT_BASE + 16'd1, 3'd0, ERR_AFTER);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkAll("midreset", 16'h0000, 1'b0, 1'b0, 16'd0, 3'd0, 1'b0);
    @(negedge clk);
    {stall, jump, branch_take, call, ret, halt_req, resume} = NONE;
    rst_n = 1'b1;
    #1;
    checkAll("idle2", 16'h0000, 1'b0, 1'b0, 16'd0, 3'd0, 1'b0);
    pushExpect("idle2_to_run", 16'h0000, 1'b1, 1'b0, 16'd0, 3'd0, 1'b0);
    applyStimulus("restart1", NONE, 16'h0000, 8'h00, 16'h0001, 1'b1, 1'b0, 16'd1, 3'd0, 1'b0);

    // Let the monitor use up the queue, giving it a bounded number of cycles
    for (int i = 0; i < 5 && expQ.size() > 0; i++) begin
      @(posedge clk);
      #2;
    end
    total++;
    if (expQ.size() != 0) begin
      bad++;
      $display("[TB] FAIL drain: got %0d pending, expected 0", expQ.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
